// File: rtl/request_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, then latch one request per fresh press,
// hold it for the controller domain, release on acknowledge and enforce a lockout window.
module request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int LOCKOUT_CYCLES  = 200_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       button,
  input  logic       clear,
  output logic       request,
  output logic       busy,
  output logic       dropped,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_q;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic [LW-1:0] r_lcnt;
  logic          r_clr_seen;
  logic          r_request;
  logic          r_busy;
  logic          r_dropped;
  logic [7:0]    r_press_count;
  logic          w_press;
  logic          w_hold_done;

  assign w_press     = r_db & ~r_db_q;
  assign w_hold_done = (r_hcnt >= HOLD_LAST);

  // Synchroniser and debouncer; a level is accepted only after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DB_LAST) begin
        r_db   <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_next = S_PENDING;
        else         w_next = S_IDLE;
      end
      S_PENDING: begin
        if (w_hold_done && (clear || r_clr_seen)) w_next = S_LOCKOUT;
        else                                      w_next = S_PENDING;
      end
      S_LOCKOUT: begin
        if (r_lcnt == LOCK_LAST) w_next = S_IDLE;
        else                     w_next = S_LOCKOUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Hold/lockout counters and acknowledge memory; all restart whenever their state is left
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_hcnt     <= '0;
      r_lcnt     <= '0;
      r_clr_seen <= 1'b0;
    end else begin
      if (r_state != S_PENDING) begin
        r_hcnt     <= '0;
        r_clr_seen <= 1'b0;
      end else begin
        r_clr_seen <= r_clr_seen | clear;
        if (r_hcnt != HOLD_MAX) r_hcnt <= r_hcnt + HW'(1);
        else                    r_hcnt <= r_hcnt;
      end
      if (r_state != S_LOCKOUT) r_lcnt <= '0;
      else                      r_lcnt <= r_lcnt + LW'(1);
    end
  end

  // Registered outputs, aligned with the state register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_request     <= 1'b0;
      r_busy        <= 1'b0;
      r_dropped     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_request <= (w_next == S_PENDING);
      r_busy    <= (w_next != S_IDLE);
      r_dropped <= w_press && (r_state != S_IDLE);
      if (w_press && (r_state == S_IDLE) && (r_press_count != 8'hFF))
        r_press_count <= r_press_count + 8'd1;
      else
        r_press_count <= r_press_count;
    end
  end

  assign request     = r_request;
  assign busy        = r_busy;
  assign dropped     = r_dropped;
  assign press_count = r_press_count;

endmodule

// File: doc/request_conditioner.md
# request_conditioner

Conditions the raw pedestrian push-button into the clean `request` level consumed by the traffic-light top level. The block runs on the 100 MHz system clock and performs three steps: synchronise, debounce, then latch a single request per fresh press. The request is held long enough for the 1 Hz controller domain to sample it, and is released only after the controller acknowledges service. A lockout window follows each served request so that repeated presses cannot re-trigger the pedestrian phase.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms); minimum 1
- `HOLD_CYCLES`, default 100_000_000: minimum cycles `request` stays high once latched (1 s, covers one 1 Hz tick); minimum 1
- `LOCKOUT_CYCLES`, default 200_000_000: cycles presses are ignored after release; minimum 1

Ports:
- `clk_100MHz` input 1: system clock, all logic on rising edge
- `reset` input 1: asynchronous, active-high; clears every register
- `button` input 1: raw asynchronous push-button, active-high
- `clear` input 1: one-cycle pulse, controller finished serving the pedestrian phase
- `request` output 1: latched pedestrian request, drives top-level `request`
- `busy` output 1: high when state ≠ IDLE
- `dropped` output 1: one-cycle pulse, a debounced press was ignored
- `press_count` output 8: accepted presses, saturates at 255

## Operation
- Synchroniser: two flops, `sync1 <= button`, `sync2 <= sync1`; reset value 0.
- Debouncer:
  - Holds level `db` (reset 0) and counter `dcnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - When `sync2 != db`, `dcnt` increments. When `sync2 == db`, `dcnt` clears to 0; any bounce restarts the count.
  - On the edge where `dcnt` reaches DEBOUNCE_CYCLES, `db` takes `sync2` and `dcnt` clears.
- Press event: `press = db & ~db_q`, where `db_q` is `db` delayed one cycle. Only rising edges count; a held button never re-triggers.
- FSM states are IDLE, PENDING and LOCKOUT; reset state is IDLE.
  - IDLE: `request` = 0. On `press`, go to PENDING, increment `press_count` (saturating), clear `hcnt` and `clr_seen`.
  - PENDING: `request` = 1. `hcnt` counts up and saturates at HOLD_CYCLES. `clr_seen` sets on `clear`. The FSM exits to LOCKOUT on the first edge where `hcnt` ≥ HOLD_CYCLES−1 and (`clear` or `clr_seen`).
  - LOCKOUT: `request` = 0. `lcnt` counts from 0 and the FSM returns to IDLE on the edge where `lcnt` = LOCKOUT_CYCLES−1.
- `clear` has no effect in IDLE or LOCKOUT.
- `dropped` pulses for one cycle when `press` occurs in PENDING or LOCKOUT. Such a press is discarded, not queued.
- Presses are not queued: after LOCKOUT ends, a still-held button does not generate a request until it is released and pressed again.
- Reset asserted mid-operation: all outputs drop to 0 asynchronously, the FSM goes to IDLE and `press_count` clears. After release, a button that is still held needs a full debounce and then yields a press, because `db` restarts from 0.

## Timing
- Reset values: `request`, `busy`, `dropped` = 0; `press_count` = 0.
- Press latency: edge 0 is the first edge that samples `button` = 1, with the button stable from then on. `db` rises at edge DEBOUNCE_CYCLES+1 and `request` rises at edge DEBOUNCE_CYCLES+2.
- Hold: with `clear` already seen, `request` is high for exactly HOLD_CYCLES cycles. If `clear` arrives later, `request` falls on the edge that samples `clear`.
- Lockout lasts exactly LOCKOUT_CYCLES cycles with `request` = 0 and `busy` = 1.
- `busy` is registered alongside the state, so it is high in exactly the same cycles as PENDING and LOCKOUT.
- `dropped` goes high in the cycle following the `db` rise, which is the same cycle `request` would have risen.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, LOCKOUT_CYCLES=6.
- Clean press: `button` goes high and stays high; `clear` pulses at cycle 20 → `request` rises at edge 6 and falls at edge 20. LOCKOUT then runs for 6 cycles, and `press_count` = 1.
- Bounce: `button` toggles 1,0,1,0 on consecutive cycles, then stays at 1 → no `request` during the toggling; `request` rises 6 edges after the final 0→1 sample.
- Early clear: `clear` pulses 1 cycle after `request` rises → `request` stays high for exactly 8 cycles, then falls.
- Press during PENDING or LOCKOUT: release the button, then press again while `busy` = 1 → `dropped` pulses once, `request` stays at its current value, and `press_count` is unchanged. A button held through the end of LOCKOUT does not produce a new request.
- Reset mid-PENDING: assert `reset` while `request` = 1 → `request`, `busy` and `press_count` go to 0 immediately. With the button held, `request` rises again 6 edges after reset release.
- Saturation: 260 complete press/clear cycles → `press_count` stops at 255.
